ctrl_sequencer: RTL and testbench

Hard-wired Moore control sequencer for the Mini-SRC datapath, directly upstream of the 32-bit ALU. Steps every instruction through fetch (T0-T2) and a class-dependent execute sequence (T3-T7). Drives the ALU's opcode and IncPC inputs, plus a packed control word that gates the bus, register file, Y/Z, HI/LO, MAR/MDR, CON and I/O ports. One instruction executes at a time; there is no pipelining.

---
 rtl/ctrl_pkg.sv | 105 ++++++++++
 rtl/ctrl_sequencer_if.sv | 25 ++
 rtl/ctrl_sequencer_opcode_class_decode.sv | 51 +++++
 rtl/ctrl_sequencer.sv | 155 +++++++++++++++
 tb/tb_ctrl_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the Mini-SRC control sequencer.
//   - opcode values (IR[31:27])
//   - bit positions inside the packed control word
//   - sequencer state encoding (T0..T7 carry their step number in bits [2:0])
//   - instruction class enumeration produced by opcode_class_decode
package ctrl_pkg;

    localparam int CTRL_W = 27;
    localparam int OP_W   = 5;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // ALU select used outside the execute steps (address/PC arithmetic)
    localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

    // Control word bit positions
    localparam int PCout     = 0;
    localparam int MARin     = 1;
    localparam int IncPC_b   = 2;
    localparam int Zin       = 3;
    localparam int Zlowout   = 4;
    localparam int Zhighout  = 5;
    localparam int PCin      = 6;
    localparam int Read      = 7;
    localparam int Write     = 8;
    localparam int MDRin     = 9;
    localparam int MDRout    = 10;
    localparam int IRin      = 11;
    localparam int Gra       = 12;
    localparam int Grb       = 13;
    localparam int Grc       = 14;
    localparam int Rin       = 15;
    localparam int Rout      = 16;
    localparam int BAout     = 17;
    localparam int Cout      = 18;
    localparam int Yin       = 19;
    localparam int HIin      = 20;
    localparam int LOin      = 21;
    localparam int HIout     = 22;
    localparam int LOout     = 23;
    localparam int CONin     = 24;
    localparam int InPortout = 25;
    localparam int OutPortin = 26;

    // T0..T7 encode their step number directly; bit 3 marks the idle states.
    typedef enum logic [3:0] {
        T0       = 4'd0,
        T1       = 4'd1,
        T2       = 4'd2,
        T3       = 4'd3,
        T4       = 4'd4,
        T5       = 4'd5,
        T6       = 4'd6,
        T7       = 4'd7,
        RESET_ST = 4'd8,
        HALT     = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU3   = 4'd0,
        CL_ALU2   = 4'd1,
        CL_MULDIV = 4'd2,
        CL_IMM    = 4'd3,
        CL_LD     = 4'd4,
        CL_ST     = 4'd5,
        CL_BR     = 4'd6,
        CL_JR     = 4'd7,
        CL_JAL    = 4'd8,
        CL_IN     = 4'd9,
        CL_OUT    = 4'd10,
        CL_MFHI   = 4'd11,
        CL_MFLO   = 4'd12,
        CL_NOP    = 4'd13,
        CL_HALT   = 4'd14
    } instr_class_e;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: instruction/status inputs and control outputs of the
// sequencer. master = sequencer side, slave = datapath/environment side.
//   IR, CON_FF, Stop              : into the sequencer
//   ctrl, alu_opcode, IncPC, Run,
//   instr_done                    : out of the sequencer
interface ctrl_sequencer_if;
    logic [31:0]                 IR;
    logic                        CON_FF;
    logic                        Stop;
    logic [ctrl_pkg::CTRL_W-1:0] ctrl;
    logic [ctrl_pkg::OP_W-1:0]   alu_opcode;
    logic                        IncPC;
    logic                        Run;
    logic                        instr_done;

    modport master (
        input  IR, CON_FF, Stop,
        output ctrl, alu_opcode, IncPC, Run, instr_done
    );

    modport slave (
        output IR, CON_FF, Stop,
        input  ctrl, alu_opcode, IncPC, Run, instr_done
    );
endinterface

// File: rtl/ctrl_sequencer_opcode_class_decode.sv
// opcode_class_decode: combinational map from opcode to instruction class
// and the index of the final T-step of that class.
//   opcode      in  5 : IR[31:27]
//   instr_class out   : execute-sequence class
//   last_step   out 3 : step number (2..7) on which the instruction completes
module opcode_class_decode
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output instr_class_e    instr_class,
    output logic [2:0]      last_step
);

    // Class lookup; unknown opcodes behave as nop.
    always_comb begin
        instr_class = CL_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:     instr_class = CL_ALU3;
            OP_NEG, OP_NOT:                      instr_class = CL_ALU2;
            OP_MUL, OP_DIV:                      instr_class = CL_MULDIV;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:    instr_class = CL_IMM;
            OP_LD:                               instr_class = CL_LD;
            OP_ST:                               instr_class = CL_ST;
            OP_BR:                               instr_class = CL_BR;
            OP_JR:                               instr_class = CL_JR;
            OP_JAL:                              instr_class = CL_JAL;
            OP_IN:                               instr_class = CL_IN;
            OP_OUT:                              instr_class = CL_OUT;
            OP_MFHI:                             instr_class = CL_MFHI;
            OP_MFLO:                             instr_class = CL_MFLO;
            OP_HALT:                             instr_class = CL_HALT;
            default:                             instr_class = CL_NOP;
        endcase
    end

    // Final step per class.
    always_comb begin
        last_step = 3'd2;
        case (instr_class)
            CL_ALU3, CL_IMM:                 last_step = 3'd5;
            CL_ALU2, CL_JAL:                 last_step = 3'd4;
            CL_MULDIV, CL_BR:                last_step = 3'd6;
            CL_LD, CL_ST:                    last_step = 3'd7;
            CL_JR, CL_IN, CL_OUT,
            CL_MFHI, CL_MFLO:                last_step = 3'd3;
            default:                         last_step = 3'd2;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hard-wired Moore sequencer for the Mini-SRC datapath.
// Fetch in T0-T2, class-dependent execute in T3-T7, one instruction at a time.
//   clock  in : rising-edge clock
//   clear  in : asynchronous active-low reset
//   bus       : ctrl_sequencer_if.master (IR, CON_FF, Stop in;
//               ctrl, alu_opcode, IncPC, Run, instr_done out)
module ctrl_sequencer
    import ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    ctrl_sequencer_if.master bus
);

    state_e              state_r;
    state_e              next_state_s;
    instr_class_e        cls_s;
    logic [2:0]          last_step_s;
    logic                is_last_s;
    logic [CTRL_W-1:0]   ctrl_s;
    logic [OP_W-1:0]     opcode_s;
    logic                unused_ok_s;

    assign opcode_s = bus.IR[31:27];
    // Operand fields are consumed by the datapath; CON_FF feeds the ALU directly.
    assign unused_ok_s = ^{bus.IR[26:0], bus.CON_FF};

    opcode_class_decode u_decode (
        .opcode      (opcode_s),
        .instr_class (cls_s),
        .last_step   (last_step_s)
    );

    // Bit 3 clear means a T-step; its low bits are the step number.
    assign is_last_s = (state_r[3] == 1'b0) && (state_r[2:0] == last_step_s);

    // State register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= RESET_ST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = RESET_ST;
        case (state_r)
            RESET_ST: next_state_s = T0;
            HALT:     next_state_s = HALT;
            T0, T1, T2, T3, T4, T5, T6, T7: begin
                if (is_last_s) begin
                    if (bus.Stop || (cls_s == CL_HALT)) begin
                        next_state_s = HALT;
                    end else begin
                        next_state_s = T0;
                    end
                end else begin
                    next_state_s = state_e'(state_r + 4'd1);
                end
            end
            default:  next_state_s = RESET_ST;
        endcase
    end

    // Control word decode from state and instruction class.
    always_comb begin
        ctrl_s = {CTRL_W{1'b0}};
        case (state_r)
            T0: begin
                ctrl_s[PCout] = 1'b1; ctrl_s[MARin] = 1'b1;
                ctrl_s[IncPC_b] = 1'b1; ctrl_s[Zin] = 1'b1;
            end
            T1: begin
                ctrl_s[Zlowout] = 1'b1; ctrl_s[PCin] = 1'b1;
                ctrl_s[Read] = 1'b1; ctrl_s[MDRin] = 1'b1;
            end
            T2: begin
                ctrl_s[MDRout] = 1'b1; ctrl_s[IRin] = 1'b1;
            end
            T3: begin
                case (cls_s)
                    CL_ALU3:   begin ctrl_s[Grb] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[Yin] = 1'b1; end
                    CL_ALU2:   begin ctrl_s[Grb] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[Zin] = 1'b1; end
                    CL_MULDIV: begin ctrl_s[Gra] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[Yin] = 1'b1; end
                    CL_IMM: begin
                        ctrl_s[Grb] = 1'b1; ctrl_s[Yin] = 1'b1;
                        // ldi adds to the base-address bus so R0 reads as zero
                        if (opcode_s == OP_LDI) begin
                            ctrl_s[BAout] = 1'b1;
                        end else begin
                            ctrl_s[Rout] = 1'b1;
                        end
                    end
                    CL_LD, CL_ST: begin ctrl_s[Grb] = 1'b1; ctrl_s[BAout] = 1'b1; ctrl_s[Yin] = 1'b1; end
                    CL_BR:     begin ctrl_s[Gra] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[CONin] = 1'b1; end
                    CL_JR:     begin ctrl_s[Gra] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[PCin] = 1'b1; end
                    CL_JAL:    begin ctrl_s[PCout] = 1'b1; ctrl_s[Grb] = 1'b1; ctrl_s[Rin] = 1'b1; end
                    CL_IN:     begin ctrl_s[InPortout] = 1'b1; ctrl_s[Gra] = 1'b1; ctrl_s[Rin] = 1'b1; end
                    CL_OUT:    begin ctrl_s[Gra] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[OutPortin] = 1'b1; end
                    CL_MFHI:   begin ctrl_s[HIout] = 1'b1; ctrl_s[Gra] = 1'b1; ctrl_s[Rin] = 1'b1; end
                    CL_MFLO:   begin ctrl_s[LOout] = 1'b1; ctrl_s[Gra] = 1'b1; ctrl_s[Rin] = 1'b1; end
                    default:   ctrl_s = {CTRL_W{1'b0}};
                endcase
            end
            T4: begin
                case (cls_s)
                    CL_ALU3:   begin ctrl_s[Grc] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[Zin] = 1'b1; end
                    CL_ALU2:   begin ctrl_s[Zlowout] = 1'b1; ctrl_s[Gra] = 1'b1; ctrl_s[Rin] = 1'b1; end
                    CL_MULDIV: begin ctrl_s[Grb] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[Zin] = 1'b1; end
                    CL_IMM, CL_LD, CL_ST: begin ctrl_s[Cout] = 1'b1; ctrl_s[Zin] = 1'b1; end
                    CL_BR:     begin ctrl_s[PCout] = 1'b1; ctrl_s[Yin] = 1'b1; end
                    CL_JAL:    begin ctrl_s[Gra] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[PCin] = 1'b1; end
                    default:   ctrl_s = {CTRL_W{1'b0}};
                endcase
            end
            T5: begin
                case (cls_s)
                    CL_ALU3, CL_IMM: begin ctrl_s[Zlowout] = 1'b1; ctrl_s[Gra] = 1'b1; ctrl_s[Rin] = 1'b1; end
                    CL_MULDIV:    begin ctrl_s[Zlowout] = 1'b1; ctrl_s[LOin] = 1'b1; end
                    CL_LD, CL_ST: begin ctrl_s[Zlowout] = 1'b1; ctrl_s[MARin] = 1'b1; end
                    CL_BR:        begin ctrl_s[Cout] = 1'b1; ctrl_s[Zin] = 1'b1; end
                    default:      ctrl_s = {CTRL_W{1'b0}};
                endcase
            end
            T6: begin
                case (cls_s)
                    CL_MULDIV: begin ctrl_s[Zhighout] = 1'b1; ctrl_s[HIin] = 1'b1; end
                    CL_LD:     begin ctrl_s[Read] = 1'b1; ctrl_s[MDRin] = 1'b1; end
                    CL_ST:     begin ctrl_s[Gra] = 1'b1; ctrl_s[Rout] = 1'b1; ctrl_s[MDRin] = 1'b1; end
                    // PCin is unconditional: the ALU passes Y through when not taken
                    CL_BR:     begin ctrl_s[Zlowout] = 1'b1; ctrl_s[PCin] = 1'b1; end
                    default:   ctrl_s = {CTRL_W{1'b0}};
                endcase
            end
            T7: begin
                case (cls_s)
                    CL_LD:   begin ctrl_s[MDRout] = 1'b1; ctrl_s[Gra] = 1'b1; ctrl_s[Rin] = 1'b1; end
                    CL_ST:   begin ctrl_s[MDRout] = 1'b1; ctrl_s[Write] = 1'b1; end
                    default: ctrl_s = {CTRL_W{1'b0}};
                endcase
            end
            default: ctrl_s = {CTRL_W{1'b0}};
        endcase
    end

    assign bus.ctrl       = ctrl_s;
    assign bus.IncPC      = (state_r == T0);
    assign bus.Run        = (state_r != RESET_ST) && (state_r != HALT);
    assign bus.instr_done = is_last_s;
    // Execute steps (T3..T7) select the instruction's ALU function.
    assign bus.alu_opcode = ((state_r[3] == 1'b0) && (state_r[2:0] >= 3'd3)) ? opcode_s : ALU_ADD;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer.
module tb_ctrl_sequencer;

    // Control word masks, bit positions written out independently of the design.
    localparam logic [26:0] M_PCOUT   = 27'd1 << 0;
    localparam logic [26:0] M_MARIN   = 27'd1 << 1;
    localparam logic [26:0] M_INCPC   = 27'd1 << 2;
    localparam logic [26:0] M_ZIN     = 27'd1 << 3;
    localparam logic [26:0] M_ZLOW    = 27'd1 << 4;
    localparam logic [26:0] M_ZHIGH   = 27'd1 << 5;
    localparam logic [26:0] M_PCIN    = 27'd1 << 6;
    localparam logic [26:0] M_READ    = 27'd1 << 7;
    localparam logic [26:0] M_WRITE   = 27'd1 << 8;
    localparam logic [26:0] M_MDRIN   = 27'd1 << 9;
    localparam logic [26:0] M_MDROUT  = 27'd1 << 10;
    localparam logic [26:0] M_IRIN    = 27'd1 << 11;
    localparam logic [26:0] M_GRA     = 27'd1 << 12;
    localparam logic [26:0] M_GRB     = 27'd1 << 13;
    localparam logic [26:0] M_GRC     = 27'd1 << 14;
    localparam logic [26:0] M_RIN     = 27'd1 << 15;
    localparam logic [26:0] M_ROUT    = 27'd1 << 16;
    localparam logic [26:0] M_BAOUT   = 27'd1 << 17;
    localparam logic [26:0] M_COUT    = 27'd1 << 18;
    localparam logic [26:0] M_YIN     = 27'd1 << 19;
    localparam logic [26:0] M_HIIN    = 27'd1 << 20;
    localparam logic [26:0] M_LOIN    = 27'd1 << 21;
    localparam logic [26:0] M_CONIN   = 27'd1 << 24;

    localparam logic [26:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [26:0] F1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [26:0] F2 = M_MDROUT | M_IRIN;
    localparam logic [4:0]  ADD_OP = 5'b00011;

    logic clock;
    logic clear;
    int   checks;
    int   errors;

    ctrl_sequencer_if bus ();

    ctrl_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all outputs of the current step, then move to the next step.
    task automatic step(input string tag, input logic [26:0] exp_ctrl, input logic [4:0] exp_alu,
                        input logic exp_inc, input logic exp_done, input logic exp_run);
        #1;
        check({tag, " ctrl"}, {5'd0, bus.ctrl}, {5'd0, exp_ctrl});
        check({tag, " alu"}, {27'd0, bus.alu_opcode}, {27'd0, exp_alu});
        check({tag, " incpc"}, {31'd0, bus.IncPC}, {31'd0, exp_inc});
        check({tag, " done"}, {31'd0, bus.instr_done}, {31'd0, exp_done});
        check({tag, " run"}, {31'd0, bus.Run}, {31'd0, exp_run});
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string tag, input logic t2_done);
        step({tag, " T0"}, F0, ADD_OP, 1'b1, 1'b0, 1'b1);
        step({tag, " T1"}, F1, ADD_OP, 1'b0, 1'b0, 1'b1);
        step({tag, " T2"}, F2, ADD_OP, 1'b0, t2_done, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear = 1'b0;
        bus.IR = {5'b00011, 27'd0};
        bus.CON_FF = 1'b0;
        bus.Stop = 1'b0;

        // Held in reset for three cycles
        repeat (3) @(posedge clock);
        #1;
        step("reset", 27'd0, ADD_OP, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        @(posedge clock);
        #1;

        // add
        fetch("add", 1'b0);
        step("add T3", M_GRB | M_ROUT | M_YIN, 5'b00011, 1'b0, 1'b0, 1'b1);
        step("add T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b0, 1'b0, 1'b1);
        step("add T5", M_ZLOW | M_GRA | M_RIN, 5'b00011, 1'b0, 1'b1, 1'b1);

        // mul
        bus.IR = {5'b01111, 27'h155};
        fetch("mul", 1'b0);
        step("mul T3", M_GRA | M_ROUT | M_YIN, 5'b01111, 1'b0, 1'b0, 1'b1);
        step("mul T4", M_GRB | M_ROUT | M_ZIN, 5'b01111, 1'b0, 1'b0, 1'b1);
        step("mul T5", M_ZLOW | M_LOIN, 5'b01111, 1'b0, 1'b0, 1'b1);
        step("mul T6", M_ZHIGH | M_HIIN, 5'b01111, 1'b0, 1'b1, 1'b1);

        // ld
        bus.IR = {5'b00000, 27'h0ABCDEF};
        fetch("ld", 1'b0);
        step("ld T3", M_GRB | M_BAOUT | M_YIN, 5'b00000, 1'b0, 1'b0, 1'b1);
        step("ld T4", M_COUT | M_ZIN, 5'b00000, 1'b0, 1'b0, 1'b1);
        step("ld T5", M_ZLOW | M_MARIN, 5'b00000, 1'b0, 1'b0, 1'b1);
        step("ld T6", M_READ | M_MDRIN, 5'b00000, 1'b0, 1'b0, 1'b1);
        step("ld T7", M_MDROUT | M_GRA | M_RIN, 5'b00000, 1'b0, 1'b1, 1'b1);

        // branch, not taken then taken: identical sequences
        for (int c = 0; c < 2; c++) begin
            bus.IR = {5'b10011, 27'd7};
            bus.CON_FF = (c == 1);
            fetch("br", 1'b0);
            step("br T3", M_GRA | M_ROUT | M_CONIN, 5'b10011, 1'b0, 1'b0, 1'b1);
            step("br T4", M_PCOUT | M_YIN, 5'b10011, 1'b0, 1'b0, 1'b1);
            step("br T5", M_COUT | M_ZIN, 5'b10011, 1'b0, 1'b0, 1'b1);
            step("br T6", M_ZLOW | M_PCIN, 5'b10011, 1'b0, 1'b1, 1'b1);
        end
        bus.CON_FF = 1'b0;

        // jal
        bus.IR = {5'b10101, 27'd0};
        fetch("jal", 1'b0);
        step("jal T3", M_PCOUT | M_GRB | M_RIN, 5'b10101, 1'b0, 1'b0, 1'b1);
        step("jal T4", M_GRA | M_ROUT | M_PCIN, 5'b10101, 1'b0, 1'b1, 1'b1);

        // nop finishes at T2
        bus.IR = {5'b11010, 27'd0};
        fetch("nop", 1'b1);

        // add with a Stop pulse that drops before the final step
        bus.IR = {5'b00011, 27'd0};
        fetch("addp", 1'b0);
        step("addp T3", M_GRB | M_ROUT | M_YIN, 5'b00011, 1'b0, 1'b0, 1'b1);
        bus.Stop = 1'b1;
        step("addp T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b0, 1'b0, 1'b1);
        bus.Stop = 1'b0;
        step("addp T5", M_ZLOW | M_GRA | M_RIN, 5'b00011, 1'b0, 1'b1, 1'b1);

        // add with Stop held into the final step -> HALT
        fetch("adds", 1'b0);
        step("adds T3", M_GRB | M_ROUT | M_YIN, 5'b00011, 1'b0, 1'b0, 1'b1);
        bus.Stop = 1'b1;
        step("adds T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b0, 1'b0, 1'b1);
        step("adds T5", M_ZLOW | M_GRA | M_RIN, 5'b00011, 1'b0, 1'b1, 1'b1);
        bus.Stop = 1'b0;
        step("halt1", 27'd0, ADD_OP, 1'b0, 1'b0, 1'b0);
        step("halt2", 27'd0, ADD_OP, 1'b0, 1'b0, 1'b0);

        // Reset out of HALT, then st interrupted by clear in T3
        clear = 1'b0;
        #1;
        clear = 1'b1;
        @(posedge clock);
        #1;
        bus.IR = {5'b00010, 27'd0};
        fetch("st", 1'b0);
        #1;
        check("st T3 ctrl", {5'd0, bus.ctrl}, {5'd0, M_GRB | M_BAOUT | M_YIN});
        check("st T3 alu", {27'd0, bus.alu_opcode}, 32'h2);
        clear = 1'b0;
        #1;
        check("st clr ctrl", {5'd0, bus.ctrl}, 32'd0);
        check("st clr run", {31'd0, bus.Run}, 32'd0);
        check("st clr alu", {27'd0, bus.alu_opcode}, {27'd0, ADD_OP});
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            check("st clr write", {31'd0, bus.ctrl[8]}, 32'd0);
            check("st clr ctrl held", {5'd0, bus.ctrl}, 32'd0);
        end

        // halt opcode finishes at T2 and parks in HALT
        clear = 1'b1;
        bus.IR = {5'b11011, 27'd0};
        @(posedge clock);
        #1;
        fetch("hlt", 1'b1);
        step("hlt HALT1", 27'd0, ADD_OP, 1'b0, 1'b0, 1'b0);
        step("hlt HALT2", 27'd0, ADD_OP, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
